radiant_trigger_scheduler: RTL



---
 rtl/radiant_trigger_scheduler.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/radiant_trigger_scheduler.sv
// RADIANT trigger scheduler: source qualification, holdoff, buffer tracking and soft flow control.
// Define RADIANT_TRIG_TIMESTAMP_EN to add a free-running cycle counter and the trig_time_o port.
module radiant_trigger_scheduler #(
  parameter int unsigned NUM_SRC       = 4,
  parameter int unsigned NUM_BUF       = 4,
  parameter int unsigned PRESCALE_BITS = 8,
  parameter int unsigned HOLDOFF_BITS  = 8,
  parameter int unsigned EXT_LEN_BITS  = 5
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic [NUM_SRC-1:0]                 src_trig_i,
  input  logic [NUM_SRC-1:0]                 src_en_i,
  input  logic [NUM_SRC*PRESCALE_BITS-1:0]   prescale_i,
  input  logic [HOLDOFF_BITS-1:0]            holdoff_i,
  input  logic                               soft_flow_ctrl_i,
  input  logic                               soft_flow_clr_i,
  input  logic [NUM_SRC-1:0]                 ext_en_i,
  input  logic [EXT_LEN_BITS-1:0]            ext_len_i,
  input  logic                               readout_done_i,
  output logic                               trig_o,
  output logic [NUM_SRC-1:0]                 trig_src_o,
  output logic [15:0]                        trig_seq_o,
  output logic                               deadtrig_o,
  output logic [15:0]                        deadtrig_count_o,
  output logic                               ext_trig_o,
  output logic                               busy_o,
  output logic                               soft_flow_waiting_o,
`ifdef RADIANT_TRIG_TIMESTAMP_EN
  output logic [31:0]                        trig_time_o,
`endif
  output logic [$clog2(NUM_BUF+1)-1:0]       outstanding_o
);

  localparam int unsigned CNT_W = $clog2(NUM_BUF + 1);
  localparam logic [CNT_W-1:0] BUF_FULL = CNT_W'(NUM_BUF);

  typedef enum logic [1:0] {ARMED, HOLDOFF, FLOW_WAIT, FULL} state_t;

  state_t                                  state;
  state_t                                  state_n;
  logic [NUM_SRC-1:0][PRESCALE_BITS-1:0]   pcnt;
  logic [HOLDOFF_BITS-1:0]                 hcnt;
  logic [EXT_LEN_BITS-1:0]                 ecnt;
  logic [NUM_SRC-1:0]                      live_c;
  logic [NUM_SRC-1:0]                      hit_c;
  logic                                    fire_c;
  logic                                    dead_c;
  logic                                    ext_fire_c;

  // Source qualification: only an armed scheduler can turn a pulse into a hit.
  always_comb begin
    live_c = src_trig_i & src_en_i;
    hit_c  = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      hit_c[k] = live_c[k] && (state == ARMED) &&
                 (pcnt[k] == prescale_i[k*PRESCALE_BITS +: PRESCALE_BITS]);
    end
    fire_c     = |hit_c;
    dead_c     = (|live_c) && (state != ARMED);
    ext_fire_c = |(hit_c & ext_en_i);
  end

  // Next state; flow wait takes precedence over a full buffer when holdoff ends.
  always_comb begin
    state_n = state;
    case (state)
      ARMED:     if (fire_c) state_n = HOLDOFF;
      HOLDOFF: begin
        if (hcnt == '0) begin
          if (soft_flow_ctrl_i)             state_n = FLOW_WAIT;
          else if (outstanding_o == BUF_FULL) state_n = FULL;
          else                              state_n = ARMED;
        end
      end
      FLOW_WAIT: if (soft_flow_clr_i) state_n = (outstanding_o == BUF_FULL) ? FULL : ARMED;
      FULL:      if (outstanding_o != BUF_FULL) state_n = ARMED;
      default:   state_n = ARMED;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state               <= ARMED;
      pcnt                <= '0;
      hcnt                <= '0;
      ecnt                <= '0;
      trig_o              <= 1'b0;
      trig_src_o          <= '0;
      trig_seq_o          <= '0;
      deadtrig_o          <= 1'b0;
      deadtrig_count_o    <= '0;
      ext_trig_o          <= 1'b0;
      busy_o              <= 1'b0;
      soft_flow_waiting_o <= 1'b0;
      outstanding_o       <= '0;
    end else begin
      state               <= state_n;
      busy_o              <= (state_n != ARMED);
      soft_flow_waiting_o <= (state_n == FLOW_WAIT);
      trig_o              <= fire_c;
      deadtrig_o          <= dead_c;

      if (dead_c && (deadtrig_count_o != 16'hFFFF))
        deadtrig_count_o <= deadtrig_count_o + 16'd1;

      if (fire_c) begin
        trig_src_o <= hit_c;
        trig_seq_o <= trig_seq_o + 16'd1;
        hcnt       <= holdoff_i;
      end else if ((state == HOLDOFF) && (hcnt != '0)) begin
        hcnt <= hcnt - HOLDOFF_BITS'(1);
      end

      // A fire and a readout in the same cycle cancel out.
      if (fire_c && !readout_done_i)
        outstanding_o <= outstanding_o + CNT_W'(1);
      else if (!fire_c && readout_done_i && (outstanding_o != '0))
        outstanding_o <= outstanding_o - CNT_W'(1);

      if (ext_fire_c) begin
        ext_trig_o <= 1'b1;
        ecnt       <= ext_len_i;
      end else if (ext_trig_o) begin
        if (ecnt == '0) ext_trig_o <= 1'b0;
        else            ecnt       <= ecnt - EXT_LEN_BITS'(1);
      end

      // Prescale counters only advance on enabled pulses seen while armed.
      for (int k = 0; k < NUM_SRC; k++) begin
        if (!src_en_i[k])
          pcnt[k] <= '0;
        else if ((state == ARMED) && src_trig_i[k])
          pcnt[k] <= hit_c[k] ? '0 : pcnt[k] + PRESCALE_BITS'(1);
      end
    end
  end

`ifdef RADIANT_TRIG_TIMESTAMP_EN
  logic [31:0] tstamp;

  // Timestamp of the qualifying cycle, published alongside the sequence number.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tstamp      <= '0;
      trig_time_o <= '0;
    end else begin
      tstamp <= tstamp + 32'd1;
      if (fire_c) trig_time_o <= tstamp;
    end
  end
`endif

endmodule
